// File: rtl/aes_round_ctrl.sv
// AES block sequencer: walks one block through an external round datapath,
// fetching round keys 0..NR from a key source and emitting the ciphertext.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data_in,
    output logic         busy,
    output logic         key_req,
    output logic [3:0]   key_idx,
    input  logic         key_vld,
    input  logic [127:0] round_key,
    output logic [127:0] dp_state,
    output logic         last_round,
    input  logic [127:0] dp_result,
    output logic [127:0] data_out,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        KEY  = 1'b1
    } fsm_t;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    fsm_t         fsm_q;
    logic [127:0] state_q;
    logic [127:0] state_d;
    logic [127:0] data_out_q;
    logic [3:0]   key_idx_q;
    logic         done_q;

    // Key handshake: key_req is high for the whole block and key_idx stays
    // stable until key_vld is seen with it; that cycle consumes the key.
    // key_vld while key_req is low has no effect.
    always_comb begin
        state_d = ((key_idx_q == 4'd0) ? state_q : dp_result) ^ round_key;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            data_out_q <= '0;
            key_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= data_in;
                        key_idx_q <= '0;
                        fsm_q     <= KEY;
                    end
                end
                KEY: begin
                    if (key_vld) begin
                        state_q <= state_d;
                        if (key_idx_q == LAST_IDX) begin
                            data_out_q <= state_d;
                            done_q     <= 1'b1;
                            key_idx_q  <= '0;
                            fsm_q      <= IDLE;
                        end else begin
                            key_idx_q <= key_idx_q + 4'd1;
                        end
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign busy       = (fsm_q == KEY);
    assign key_req    = busy;
    assign key_idx    = key_idx_q;
    assign dp_state   = state_q;
    assign last_round = (fsm_q == KEY) && (key_idx_q == LAST_IDX);
    assign data_out   = data_out_q;
    assign done       = done_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: AES round datapath and key schedule model around
// the sequencer, with a scoreboard of expected ciphertexts and completion cycles.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic         busy;
    logic         key_req;
    logic [3:0]   key_idx;
    logic         key_vld;
    logic [127:0] round_key;
    logic [127:0] dp_state;
    logic         last_round;
    logic [127:0] dp_result;
    logic [127:0] data_out;
    logic         done;

    aes_round_ctrl #(.NR(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .busy       (busy),
        .key_req    (key_req),
        .key_idx    (key_idx),
        .key_vld    (key_vld),
        .round_key  (round_key),
        .dp_state   (dp_state),
        .last_round (last_round),
        .dp_result  (dp_result),
        .data_out   (data_out),
        .done       (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- AES model ----------------
    function automatic logic [7:0] sb(input int x);
        return SBOX[2047 - 8 * x -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_dp(input logic [127:0] s, input logic last);
        logic [7:0]   b[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sb(int'(s[127 - 8 * i -: 8]));
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r + 4 * c] = b[r + 4 * ((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
            if (!last) begin
                t[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = t[i];
        return o;
    endfunction

    logic [127:0] rk [0:NR];

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb(int'(tmp[23:16])), sb(int'(tmp[15:8])),
                       sb(int'(tmp[7:0])), sb(int'(tmp[31:24]))} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < NR; r++) s = aes_dp(s, 1'b0) ^ rk[r];
        return aes_dp(s, 1'b1) ^ rk[NR];
    endfunction

    always_comb dp_result = aes_dp(dp_state, last_round);

    // ---------------- key source ----------------
    typedef enum {KV_ALWAYS, KV_STALL, KV_RAND} kv_mode_t;
    kv_mode_t kv_mode = KV_ALWAYS;

    initial begin
        int   stall_cnt;
        logic pb;
        stall_cnt = 0;
        pb        = 1'b0;
        key_vld   = 1'b0;
        round_key = '0;
        forever begin
            @(posedge clk);
            #1;
            case (kv_mode)
                KV_ALWAYS: key_vld = 1'b1;
                KV_STALL: begin
                    if (!busy || !pb) stall_cnt = 0;
                    else if (stall_cnt >= 3) stall_cnt = 0;
                    else stall_cnt++;
                    key_vld = busy && (stall_cnt >= 3);
                end
                default: key_vld = 1'($urandom_range(0, 1));
            endcase
            pb = busy;
            if (key_vld && int'(key_idx) <= NR) round_key = rk[key_idx];
            else round_key = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    logic [127:0] exp_q[$];
    int           due_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    int hold_lo = -1;
    int hold_hi = -1;

    logic         p_busy = 1'b0;
    logic         p_kv = 1'b0;
    logic         p_rst = 1'b1;
    logic [3:0]   p_idx = '0;
    logic [127:0] p_state = '0;
    logic [127:0] p_out = '0;

    always @(negedge clk) begin
        check("key_req", 128'(key_req), 128'(busy));
        check("last_round", 128'(last_round), 128'(busy && (key_idx == 4'(NR))));
        if (!busy) check("idle_key_idx", 128'(key_idx), 128'(0));
        if (!p_rst && p_busy && !p_kv && busy) begin
            check("stall_key_idx", 128'(key_idx), 128'(p_idx));
            check("stall_state", dp_state, p_state);
        end
        if (!p_rst && !done) check("data_out_hold", data_out, p_out);
        if (cyc >= hold_lo && cyc <= hold_hi) check("busy_vs_done", 128'(busy), 128'(!done));
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 128'(done), 128'(0));
            end else begin
                logic [127:0] e;
                int           d;
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("data_out", data_out, e);
                if (d != 0) check("done_cycle", 128'(cyc), 128'(d));
            end
        end
        p_busy  = busy;
        p_kv    = key_vld;
        p_rst   = rst;
        p_idx   = key_idx;
        p_state = dp_state;
        p_out   = data_out;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check("idle_timeout", 128'(busy), 128'(0));
    endtask

    task automatic send_block(input logic [127:0] pt, input logic [127:0] ct, input int lat);
        wait_idle();
        start   = 1'b1;
        data_in = pt;
        exp_q.push_back(ct);
        due_q.push_back((lat == 0) ? 0 : cyc + lat);
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic check_cleared(input string pfx);
        check({pfx, "_busy"}, 128'(busy), 128'(0));
        check({pfx, "_key_req"}, 128'(key_req), 128'(0));
        check({pfx, "_key_idx"}, 128'(key_idx), 128'(0));
        check({pfx, "_last_round"}, 128'(last_round), 128'(0));
        check({pfx, "_done"}, 128'(done), 128'(0));
        check({pfx, "_dp_state"}, dp_state, 128'(0));
        check({pfx, "_data_out"}, data_out, 128'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        logic [127:0] pt;

        set_key(FIPS_KEY);
        rst     = 1'b1;
        start   = 1'b1;
        data_in = FIPS_PT;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst   = 1'b0;
        start = 1'b0;

        // FIPS-197 vector with keys always available
        send_block(FIPS_PT, FIPS_CT, 12);
        drain();

        // three-cycle stall before every key
        kv_mode = KV_STALL;
        send_block(FIPS_PT, FIPS_CT, 45);
        drain();
        kv_mode = KV_ALWAYS;

        // start pulses during a block must be ignored
        pt = {$urandom, $urandom, $urandom, $urandom};
        k  = cyc;
        send_block(pt, aes_ref(pt), 12);
        while (cyc < k + 3) begin @(posedge clk); #1; end
        start   = 1'b1;
        data_in = FIPS_PT;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < k + 7) begin @(posedge clk); #1; end
        start   = 1'b1;
        data_in = ~pt;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        check("pulse_busy", 128'(busy), 128'(0));

        // start held high: back-to-back blocks
        wait_idle();
        pt      = {$urandom, $urandom, $urandom, $urandom};
        k       = cyc;
        hold_lo = k + 1;
        hold_hi = k + 36;
        start   = 1'b1;
        data_in = pt;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(aes_ref(pt));
            due_q.push_back(k + 12 * i);
        end
        repeat (25) begin @(posedge clk); #1; end
        start = 1'b0;
        drain();
        hold_lo = -1;
        hold_hi = -1;

        // reset in the middle of a block
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, aes_ref(pt), 12);
        k = 0;
        while (key_idx != 4'd5 && k < 30) begin @(posedge clk); #1; k++; end
        check("reached_idx5", 128'(key_idx), 128'(5));
        rst = 1'b1;
        exp_q.delete();
        due_q.delete();
        @(posedge clk); #1;
        check_cleared("abort");
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        send_block(FIPS_PT, FIPS_CT, 12);
        drain();

        // random keys, plaintexts and key_vld pattern
        set_key({$urandom, $urandom, $urandom, $urandom});
        kv_mode = KV_RAND;
        for (int i = 0; i < 4; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            send_block(pt, aes_ref(pt), 0);
        end
        drain();
        kv_mode = KV_ALWAYS;

        repeat (3) begin @(posedge clk); #1; end
        check("blocks_completed", 128'(n_done), 128'(11));
        check("leftover", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
